popcount_enum8: RTL and testbench

- Inverse companion to the 8-bit popcount block. It takes a target count k on a valid/ready input.
- It then streams, one word per accepted output beat, every W-bit word whose population count equals k, in ascending numeric order. The last word is flagged.
- Used as a pattern source for exercising popcount datapaths and as a k-of-W mask generator.

---
 rtl/popcount_enum8.sv | 188 ++++++++++++++++++
 tb/tb_popcount_enum8.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/popcount_enum8.sv
// k-of-W pattern enumerator: streams every W-bit word with popcount k in ascending order.
// Optional self-check is built when POPCOUNT_ENUM_CHECK_EN is defined; otherwise O_mismatch is tied low.
module popcount_enum8 #(
    parameter int W    = 8,
    parameter int CW   = 4,
    parameter int IDXW = 7
) (
    input  logic            CLK,
    input  logic            ASYNCRESET,
    input  logic [CW-1:0]   I,
    input  logic            I_valid,
    output logic            I_ready,
    output logic [W-1:0]    O,
    output logic            O_valid,
    input  logic            O_ready,
    output logic            O_last,
    output logic [IDXW-1:0] O_index,
    output logic            O_err,
    output logic            O_mismatch
);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   k_q, k_d;
    logic [W-1:0]    word_q, word_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            err_q, err_d;
    logic            beat_s;

    // Low k bits set; saturates to all ones when k >= W.
    function automatic logic [W-1:0] low_mask(input logic [CW-1:0] k);
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < W; i++) begin
            m[i] = (i < int'(k));
        end
        return m;
    endfunction

    // High k bits set: the final word of an enumeration for legal k.
    function automatic logic [W-1:0] last_mask(input logic [CW-1:0] k);
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < W; i++) begin
            m[i] = ((i + int'(k)) >= W);
        end
        return m;
    endfunction

    // Gosper's hack; the carry is kept in W+1 bits and the divide by c is a shift by ctz(c).
    function automatic logic [W-1:0] gosper_next(input logic [W-1:0] x);
        logic [W:0] c;
        logic [W:0] r;
        logic [W:0] n;
        int         tz;
        c  = {1'b0, x & (~x + W'(1))};
        r  = {1'b0, x} + c;
        tz = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (c[i]) begin
                tz = i;
            end
        end
        n = r | (((r ^ {1'b0, x}) >> 2) >> tz);
        return n[W-1:0];
    endfunction

    assign beat_s     = (state_q == ST_RUN) && O_ready;
    assign I_ready    = (state_q == ST_IDLE);
    assign O_valid    = (state_q == ST_RUN);
    assign O          = word_q;
    assign O_index    = idx_q;
    assign O_err      = err_q;
    assign O_last     = (state_q == ST_RUN) && (err_q || (word_q == last_mask(k_q)));

    // Next-state: latch k in IDLE, step the pattern on every accepted non-final beat.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        word_d  = word_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (I_valid) begin
                    state_d = ST_RUN;
                    k_d     = I;
                    idx_d   = '0;
                    if (I > CW'(W)) begin
                        word_d = '0;
                        err_d  = 1'b1;
                    end else begin
                        word_d = low_mask(I);
                        err_d  = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (beat_s) begin
                    if (O_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        word_d = gosper_next(word_q);
                        idx_d  = idx_q + IDXW'(1);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

`ifdef POPCOUNT_ENUM_CHECK_EN
    logic         mism_q, mism_d;
    logic [W-1:0] prev_q, prev_d;
    logic         have_prev_q, have_prev_d;

    function automatic logic [CW-1:0] popcnt(input logic [W-1:0] x);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < W; i++) begin
            n = n + CW'(x[i]);
        end
        return n;
    endfunction

    // Self-check: popcount must equal k and words must strictly increase within one enumeration.
    always_comb begin
        mism_d      = mism_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        if (I_ready && I_valid) begin
            have_prev_d = 1'b0;
        end else if (beat_s) begin
            if ((!err_q && (popcnt(word_q) != k_q)) || (have_prev_q && (word_q <= prev_q))) begin
                mism_d = 1'b1;
            end else begin
                mism_d = mism_q;
            end
            prev_d      = word_q;
            have_prev_d = 1'b1;
        end else begin
            have_prev_d = have_prev_q;
        end
    end

    // Sticky mismatch flag and previous-word history.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            mism_q      <= 1'b0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
        end else begin
            mism_q      <= mism_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign O_mismatch = mism_q;
`else
    assign O_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_popcount_enum8.sv
// Randomized bench for popcount_enum8: a set-enumeration model predicts every output on every cycle.
module tb_popcount_enum8;
    localparam int W = 8;

    logic       CLK = 1'b0;
    logic       ASYNCRESET;
    logic [3:0] I;
    logic       I_valid;
    logic       I_ready;
    logic [7:0] O;
    logic       O_valid;
    logic       O_ready;
    logic       O_last;
    logic [6:0] O_index;
    logic       O_err;
    logic       O_mismatch;

    int errs   = 0;
    int checks = 0;

    int run_m  = 0;
    int pos_m  = 0;
    int k_m    = 0;
    int cnt_m  = 0;

    popcount_enum8 dut (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .I(I), .I_valid(I_valid), .I_ready(I_ready),
        .O(O), .O_valid(O_valid), .O_ready(O_ready), .O_last(O_last), .O_index(O_index),
        .O_err(O_err), .O_mismatch(O_mismatch)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Number of W-bit words with popcount k (k > W: one error word).
    function automatic int count_words(input int k);
        int c = 0;
        if (k > W) return 1;
        for (int v = 0; v < (1 << W); v++) if ($countones(v) == k) c++;
        return c;
    endfunction

    // n-th word (ascending) with popcount k.
    function automatic int nth_word(input int k, input int n);
        int c = 0;
        if (k > W) return 0;
        for (int v = 0; v < (1 << W); v++) begin
            if ($countones(v) == k) begin
                if (c == n) return v;
                c++;
            end
        end
        return -1;
    endfunction

    always @(negedge CLK) begin
        if (ASYNCRESET) begin
            run_m = 0;
            pos_m = 0;
        end else begin
            chk("O_valid", 32'(O_valid), 32'(run_m != 0));
            chk("I_ready", 32'(I_ready), 32'(run_m == 0));
            chk("O_mismatch", 32'(O_mismatch), 32'(0));
            if (run_m != 0) begin
                chk("O", 32'(O), 32'(nth_word(k_m, pos_m)));
                chk("O_index", 32'(O_index), 32'(pos_m));
                chk("O_last", 32'(O_last), 32'(pos_m == cnt_m - 1));
                chk("O_err", 32'(O_err), 32'(k_m > W));
                if (O_ready) begin
                    if (pos_m == cnt_m - 1) begin
                        run_m = 0;
                        pos_m = 0;
                    end else begin
                        pos_m++;
                    end
                end
            end else if (I_valid) begin
                run_m = 1;
                k_m   = int'(I);
                cnt_m = count_words(int'(I));
                pos_m = 0;
            end
        end
    end

    task automatic accept_k(input int k, input bit hold_valid);
        bit got = 1'b0;
        @(posedge CLK); #1;
        I       = 4'(k);
        I_valid = 1'b1;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge CLK);
            got = I_ready;
            @(posedge CLK); #1;
        end
        if (!got) chk("accept_timeout", 32'(0), 32'(1));
        if (hold_valid) I = 4'(3);
        else I_valid = 1'b0;
    endtask

    task automatic run_k(input int k, input int stall_pct, input bit hold_valid);
        bit done = 1'b0;
        accept_k(k, hold_valid);
        for (int c = 0; c < 2000 && !done; c++) begin
            O_ready = (int'($urandom_range(0, 99)) >= stall_pct);
            @(negedge CLK);
            done = O_valid && O_ready && O_last;
            @(posedge CLK); #1;
        end
        if (!done) chk("stream_timeout", 32'(0), 32'(1));
        I_valid = 1'b0;
        O_ready = 1'b0;
    endtask

    task automatic reset_mid_stream();
        bit found = 1'b0;
        accept_k(3, 1'b0);
        O_ready = 1'b1;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge CLK);
            found = O_valid && (O_index == 7'd10);
        end
        if (!found) chk("idx10_timeout", 32'(0), 32'(1));
        #2 ASYNCRESET = 1'b1;
        #1;
        chk("rst_O_valid", 32'(O_valid), 32'(0));
        chk("rst_I_ready", 32'(I_ready), 32'(1));
        chk("rst_O_index", 32'(O_index), 32'(0));
        #10 ASYNCRESET = 1'b0;
        O_ready = 1'b0;
    endtask

    initial begin
        ASYNCRESET = 1'b1;
        I          = 4'd0;
        I_valid    = 1'b0;
        O_ready    = 1'b0;
        #1;
        chk("reset_O", 32'(O), 32'(0));
        chk("reset_O_valid", 32'(O_valid), 32'(0));
        chk("reset_O_last", 32'(O_last), 32'(0));
        chk("reset_O_index", 32'(O_index), 32'(0));
        chk("reset_O_err", 32'(O_err), 32'(0));
        chk("reset_O_mismatch", 32'(O_mismatch), 32'(0));
        chk("reset_I_ready", 32'(I_ready), 32'(1));

        // Pin the model against hand-computed values.
        chk("model_k2_w0", 32'(nth_word(2, 0)), 32'h03);
        chk("model_k2_w1", 32'(nth_word(2, 1)), 32'h05);
        chk("model_k2_w2", 32'(nth_word(2, 2)), 32'h06);
        chk("model_k2_w3", 32'(nth_word(2, 3)), 32'h09);
        chk("model_k2_w4", 32'(nth_word(2, 4)), 32'h0A);
        chk("model_k2_cnt", 32'(count_words(2)), 32'd28);
        chk("model_k2_last", 32'(nth_word(2, 27)), 32'hC0);
        chk("model_k4_cnt", 32'(count_words(4)), 32'd70);
        chk("model_k4_last", 32'(nth_word(4, 69)), 32'hF0);
        chk("model_k1_last", 32'(nth_word(1, 7)), 32'h80);
        chk("model_k0_cnt", 32'(count_words(0)), 32'd1);

        #21 ASYNCRESET = 1'b0;

        run_k(0, 0, 1'b0);
        run_k(1, 0, 1'b0);
        run_k(2, 0, 1'b0);
        run_k(4, 50, 1'b0);
        run_k(8, 0, 1'b1);
        run_k(9, 0, 1'b1);
        reset_mid_stream();
        run_k(1, 0, 1'b0);
        for (int n = 0; n < 5; n++) run_k(int'($urandom_range(0, 10)), 30, 1'b0);
        run_k(6, 20, 1'b1);

        repeat (3) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
